// File: rtl/dac_write_scheduler.sv
// Round-robin scheduler sharing one 32-bit DAC SPI serializer among NUM_CH requesters.
// Sends the DAC setup frame once after reset, then builds and sequences per-channel write frames.
module dac_write_scheduler #(
   parameter int unsigned NUM_CH      = 4,
   parameter logic [3:0]  CMD_WR      = 4'h3,
   parameter logic [31:0] INIT_WORD   = 32'h08000001,
   parameter int unsigned TIMEOUT_CYC = 8192
) (
   input  logic                   clk_100mhz,
   input  logic                   rst,
   input  logic [NUM_CH-1:0]      req,
   input  logic [12*NUM_CH-1:0]   req_data,
   output logic [NUM_CH-1:0]      ack,
   output logic [31:0]            spi_frame,
   output logic                   spi_start,
   input  logic                   spi_done,
   output logic                   init_done,
   output logic                   busy,
   output logic [2:0]             grant_ch,
   output logic                   err
);

   localparam int unsigned IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int unsigned CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

   typedef enum logic [1:0] {
      ST_INIT,
      ST_INIT_WAIT,
      ST_IDLE,
      ST_WAIT
   } state_t;

   state_t              state_q;
   logic [CNT_W-1:0]    cnt_q;
   logic [2:0]          rr_ptr_q;
   logic [NUM_CH-1:0]   ack_q;
   logic [31:0]         frame_q;
   logic                start_q;
   logic                init_done_q;
   logic                busy_q;
   logic [2:0]          grant_q;
   logic                err_q;

   logic                hit_hi_c;
   logic                hit_lo_c;
   logic [2:0]          hi_c;
   logic [2:0]          lo_c;
   logic                any_req_c;
   logic [2:0]          pick_c;
   logic [2:0]          rr_next_c;
   logic [11:0]         data_c;
   logic                timeout_c;

   // Round-robin pick: first request at or above rr_ptr, else first request from channel 0.
   always_comb begin
      hit_hi_c = 1'b0;
      hit_lo_c = 1'b0;
      hi_c     = 3'd0;
      lo_c     = 3'd0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (!hit_hi_c && req[IDX_W'(i)] && (3'(i) >= rr_ptr_q)) begin
            hit_hi_c = 1'b1;
            hi_c     = 3'(i);
         end
         if (!hit_lo_c && req[IDX_W'(i)]) begin
            hit_lo_c = 1'b1;
            lo_c     = 3'(i);
         end
      end
      any_req_c = hit_lo_c;
      pick_c    = hit_hi_c ? hi_c : lo_c;
      rr_next_c = (pick_c == 3'(NUM_CH - 1)) ? 3'd0 : pick_c + 3'd1;
   end

   always_comb begin
      data_c = 12'h000;
      for (int i = 0; i < NUM_CH; i++) begin
         if (3'(i) == pick_c) begin
            data_c = req_data[12*i +: 12];
         end
      end
   end

   assign timeout_c = (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

   // Sequencer: counter restarts on every state entry; spi_done takes priority over timeout.
   always_ff @(posedge clk_100mhz or posedge rst) begin
      if (rst) begin
         state_q     <= ST_INIT;
         cnt_q       <= '0;
         rr_ptr_q    <= 3'd0;
         ack_q       <= '0;
         frame_q     <= 32'h0;
         start_q     <= 1'b0;
         init_done_q <= 1'b0;
         busy_q      <= 1'b1;
         grant_q     <= 3'd0;
         err_q       <= 1'b0;
      end else begin
         start_q <= 1'b0;
         ack_q   <= '0;
         cnt_q   <= cnt_q + CNT_W'(1);
         case (state_q)
            ST_INIT: begin
               frame_q <= INIT_WORD;
               start_q <= 1'b1;
               cnt_q   <= '0;
               state_q <= ST_INIT_WAIT;
            end
            ST_INIT_WAIT: begin
               if (spi_done) begin
                  init_done_q <= 1'b1;
                  busy_q      <= 1'b0;
                  cnt_q       <= '0;
                  state_q     <= ST_IDLE;
               end else if (timeout_c) begin
                  err_q   <= 1'b1;
                  cnt_q   <= '0;
                  state_q <= ST_INIT;
               end
            end
            ST_IDLE: begin
               cnt_q <= '0;
               if (any_req_c) begin
                  frame_q  <= {4'h0, CMD_WR, 4'(pick_c), data_c, 8'h00};
                  start_q  <= 1'b1;
                  ack_q    <= NUM_CH'(1) << pick_c;
                  grant_q  <= pick_c;
                  rr_ptr_q <= rr_next_c;
                  busy_q   <= 1'b1;
                  state_q  <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (spi_done) begin
                  busy_q  <= 1'b0;
                  cnt_q   <= '0;
                  state_q <= ST_IDLE;
               end else if (timeout_c) begin
                  err_q   <= 1'b1;
                  busy_q  <= 1'b0;
                  cnt_q   <= '0;
                  state_q <= ST_IDLE;
               end
            end
            default: begin
               busy_q  <= 1'b1;
               state_q <= ST_INIT;
            end
         endcase
      end
   end

   assign ack       = ack_q;
   assign spi_frame = frame_q;
   assign spi_start = start_q;
   assign init_done = init_done_q;
   assign busy      = busy_q;
   assign grant_ch  = grant_q;
   assign err       = err_q;

endmodule

// File: tb/tb_dac_write_scheduler.sv
// Directed bench for dac_write_scheduler: table of single grants plus hand-written
// sequences for setup, round-robin streaming, timeouts and mid-transfer reset.
module tb_dac_write_scheduler;

   localparam logic [31:0] INIT_W = 32'h08000001;

   logic        clk_100mhz = 1'b0;
   logic        rst        = 1'b1;
   logic [3:0]  req        = 4'b0000;
   logic [47:0] req_data   = 48'h0;
   logic [3:0]  ack;
   logic [31:0] spi_frame;
   logic        spi_start;
   logic        spi_done;
   logic        init_done;
   logic        busy;
   logic [2:0]  grant_ch;
   logic        err;

   logic        model_done = 1'b0;
   logic        man_done   = 1'b0;
   logic        withhold   = 1'b0;
   int          done_dly   = 3400;
   int          cyc        = 0;
   int          n_vec      = 0;
   int          n_err      = 0;

   assign spi_done = model_done | man_done;

   dac_write_scheduler dut (
      .clk_100mhz (clk_100mhz),
      .rst        (rst),
      .req        (req),
      .req_data   (req_data),
      .ack        (ack),
      .spi_frame  (spi_frame),
      .spi_start  (spi_start),
      .spi_done   (spi_done),
      .init_done  (init_done),
      .busy       (busy),
      .grant_ch   (grant_ch),
      .err        (err)
   );

   always #5 clk_100mhz = ~clk_100mhz;
   always @(posedge clk_100mhz) cyc <= cyc + 1;

   // Serializer model: pulses spi_done done_dly edges after the start edge; aborts on rst.
   initial begin
      bit aborted;
      forever begin
         @(posedge clk_100mhz); #2;
         if (spi_start && !rst && !withhold) begin
            aborted = 1'b0;
            for (int n = 1; n < done_dly; n++) begin
               @(posedge clk_100mhz); #2;
               if (rst) begin
                  aborted = 1'b1;
                  break;
               end
            end
            if (!aborted) begin
               model_done = 1'b1;
               @(posedge clk_100mhz); #2;
               model_done = 1'b0;
            end
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk_100mhz); #1;
   endtask

   task automatic wait_start(input string name, input int budget, output int waited);
      waited = 0;
      while (waited < budget) begin
         tick();
         waited++;
         if (spi_start === 1'b1) return;
      end
      chk({name, "_start_timeout"}, 32'(spi_start), 32'd1);
   endtask

   task automatic wait_idle(input string name, input int budget);
      int w;
      w = 0;
      while (w < budget) begin
         tick();
         w++;
         if (busy === 1'b0) return;
      end
      chk({name, "_idle_timeout"}, 32'(busy), 32'd0);
   endtask

   task automatic wait_init(input string name, input int budget, output int waited, output bit acked);
      waited = 0;
      acked  = 1'b0;
      while (waited < budget) begin
         tick();
         waited++;
         if (ack !== 4'b0000) acked = 1'b1;
         if (init_done === 1'b1) return;
      end
      chk({name, "_init_timeout"}, 32'(init_done), 32'd1);
   endtask

   typedef struct {
      logic [3:0]  req;
      logic [47:0] data;
      logic [3:0]  exp_ack;
      logic [31:0] exp_frame;
      logic [2:0]  exp_grant;
   } vec_t;

   vec_t tbl [6];

   initial begin
      int w;
      int prev;
      bit acked;
      logic [2:0] rr_grant [5];
      logic [31:0] rr_frame [5];

      tbl[0] = '{4'b0100, {12'h000, 12'hABC, 12'h000, 12'h000}, 4'b0100, 32'h032ABC00, 3'd2};
      tbl[1] = '{4'b0011, {12'h000, 12'h000, 12'h456, 12'h123}, 4'b0001, 32'h03012300, 3'd0};
      tbl[2] = '{4'b1001, {12'hFFF, 12'h000, 12'h000, 12'h001}, 4'b1000, 32'h033FFF00, 3'd3};
      tbl[3] = '{4'b1111, {12'h444, 12'h333, 12'h222, 12'h000}, 4'b0001, 32'h03000000, 3'd0};
      tbl[4] = '{4'b0010, {12'h000, 12'h000, 12'h7E5, 12'h000}, 4'b0010, 32'h0317E500, 3'd1};
      tbl[5] = '{4'b1000, {12'h800, 12'h000, 12'h000, 12'h000}, 4'b1000, 32'h03380000, 3'd3};
      rr_grant = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd0};
      rr_frame = '{32'h03011100, 32'h03122200, 32'h03233300, 32'h03344400, 32'h03011100};

      // Reset state, with channel 2 already requesting.
      req      = tbl[0].req;
      req_data = tbl[0].data;
      repeat (3) tick();
      chk("rst_frame", spi_frame, 32'h0);
      chk("rst_start", 32'(spi_start), 32'd0);
      chk("rst_ack", 32'(ack), 32'd0);
      chk("rst_init_done", 32'(init_done), 32'd0);
      chk("rst_grant", 32'(grant_ch), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      chk("rst_busy", 32'(busy), 32'd1);

      rst = 1'b0;
      tick();
      chk("init_start", 32'(spi_start), 32'd1);
      chk("init_frame", spi_frame, INIT_W);
      chk("init_ack", 32'(ack), 32'd0);
      wait_init("init", 5000, w, acked);
      chk("init_latency", 32'(w), 32'd3400);
      chk("init_no_ack", 32'(acked), 32'd0);

      // Table of single grants; round-robin pointer carries across entries.
      done_dly = 40;
      for (int k = 0; k < 6; k++) begin
         req      = tbl[k].req;
         req_data = tbl[k].data;
         wait_start($sformatf("vec%0d", k), 100, w);
         chk($sformatf("vec%0d_frame", k), spi_frame, tbl[k].exp_frame);
         chk($sformatf("vec%0d_ack", k), 32'(ack), 32'(tbl[k].exp_ack));
         chk($sformatf("vec%0d_grant", k), 32'(grant_ch), 32'(tbl[k].exp_grant));
         chk($sformatf("vec%0d_busy", k), 32'(busy), 32'd1);
         req      = 4'b0000;
         req_data = 48'h0;
         tick();
         chk($sformatf("vec%0d_start_width", k), 32'(spi_start), 32'd0);
         chk($sformatf("vec%0d_ack_width", k), 32'(ack), 32'd0);
         wait_idle($sformatf("vec%0d", k), 100);
      end

      // All four held: strict rotation and exactly one idle cycle between done and next start.
      done_dly = 20;
      req      = 4'b1111;
      req_data = {12'h444, 12'h333, 12'h222, 12'h111};
      prev     = 0;
      for (int j = 0; j < 5; j++) begin
         wait_start($sformatf("rr%0d", j), 100, w);
         chk($sformatf("rr%0d_grant", j), 32'(grant_ch), 32'(rr_grant[j]));
         chk($sformatf("rr%0d_frame", j), spi_frame, rr_frame[j]);
         chk($sformatf("rr%0d_ack", j), 32'(ack), 32'(4'b0001 << rr_grant[j]));
         if (j > 0) chk($sformatf("rr%0d_spacing", j), 32'(cyc - prev), 32'd21);
         prev = cyc;
      end
      req = 4'b0000;
      wait_idle("rr_end", 100);

      // spi_done and timeout on the same edge: done wins, err stays clear.
      withhold = 1'b1;
      req      = 4'b0100;
      req_data = {12'h000, 12'h5A5, 24'h0};
      wait_start("coin", 100, w);
      req = 4'b0000;
      repeat (8191) tick();
      chk("coin_busy_pre", 32'(busy), 32'd1);
      #1 man_done = 1'b1;
      tick();
      man_done = 1'b0;
      chk("coin_err", 32'(err), 32'd0);
      chk("coin_busy", 32'(busy), 32'd0);

      // WAIT timeout: frame dropped, err sticky, next request still served.
      req      = 4'b0001;
      req_data = {36'h0, 12'h321};
      wait_start("to", 100, w);
      chk("to_frame", spi_frame, 32'h03032100);
      req = 4'b0000;
      repeat (8191) tick();
      chk("to_err_pre", 32'(err), 32'd0);
      chk("to_busy_pre", 32'(busy), 32'd1);
      tick();
      chk("to_err", 32'(err), 32'd1);
      chk("to_busy", 32'(busy), 32'd0);
      withhold = 1'b0;
      req      = 4'b0010;
      req_data = {24'h0, 12'h9AB, 12'h0};
      wait_start("to_next", 100, w);
      chk("to_next_frame", spi_frame, 32'h0319AB00);
      chk("to_next_grant", 32'(grant_ch), 32'd1);
      req = 4'b0000;
      wait_idle("to_next", 100);
      chk("to_err_sticky", 32'(err), 32'd1);

      // INIT_WAIT timeout: setup frame retried, init_done only after a real done.
      withhold = 1'b1;
      rst      = 1'b1;
      tick();
      chk("iw_rst_err", 32'(err), 32'd0);
      rst = 1'b0;
      tick();
      chk("iw_start", 32'(spi_start), 32'd1);
      repeat (8191) tick();
      chk("iw_err_pre", 32'(err), 32'd0);
      tick();
      chk("iw_err", 32'(err), 32'd1);
      chk("iw_init_done", 32'(init_done), 32'd0);
      chk("iw_busy", 32'(busy), 32'd1);
      withhold = 1'b0;
      tick();
      chk("iw_restart", 32'(spi_start), 32'd1);
      chk("iw_reframe", spi_frame, INIT_W);
      wait_init("iw", 100, w, acked);
      chk("iw_done_latency", 32'(w), 32'd20);

      // Reset mid-WAIT with channel 3 pending.
      done_dly = 100;
      req      = 4'b1000;
      req_data = {12'hC0F, 36'h0};
      wait_start("mr", 100, w);
      chk("mr_grant", 32'(grant_ch), 32'd3);
      repeat (10) tick();
      rst = 1'b1;
      #1;
      chk("mr_frame", spi_frame, 32'h0);
      chk("mr_grant_rst", 32'(grant_ch), 32'd0);
      chk("mr_init_done", 32'(init_done), 32'd0);
      chk("mr_err", 32'(err), 32'd0);
      chk("mr_busy", 32'(busy), 32'd1);
      tick();
      rst = 1'b0;
      tick();
      chk("mr_init_start", 32'(spi_start), 32'd1);
      chk("mr_init_frame", spi_frame, INIT_W);
      wait_init("mr", 200, w, acked);
      chk("mr_no_ack", 32'(acked), 32'd0);
      wait_start("mr_serve", 100, w);
      chk("mr_serve_latency", 32'(w), 32'd1);
      chk("mr_serve_frame", spi_frame, 32'h033C0F00);
      chk("mr_serve_ack", 32'(ack), 32'd8);
      req = 4'b0000;
      wait_idle("mr_serve", 200);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #5ms;
      $display("FAIL global_timeout: got cycle %0d expected completion", cyc);
      $fatal(1, "bench time limit");
   end

endmodule
